// File: rtl/xbar_arbiter.sv
// Round-robin arbiter for one crossbar slave port.
// A master that wins the slave keeps it for a whole packet (until the beat
// carrying last is accepted). On release the next owner is chosen in the same
// cycle, so back-to-back packets from different masters incur no idle cycle.
// All outputs are registered; nothing from req_i reaches an output combinationally.
module xbar_arbiter #(
  parameter int S_DATA_COUNT = 2,
  localparam int IDX_WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_DATA_COUNT-1:0] req_i,
  input  logic                    valid_i,
  input  logic                    ready_i,
  input  logic                    last_i,
  output logic [S_DATA_COUNT-1:0] grant_o,
  output logic [IDX_WIDTH-1:0]    grant_idx_o,
  output logic                    grant_valid_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [IDX_WIDTH-1:0]    ptr_reg, ptr_next;
  logic [S_DATA_COUNT-1:0] grant_reg, grant_next;
  logic [IDX_WIDTH-1:0]    idx_reg, idx_next;
  logic                    grant_valid_reg, grant_valid_next;

  logic                    sel_found;
  logic [IDX_WIDTH-1:0]    sel_idx;
  logic [IDX_WIDTH-1:0]    sel_ptr_next;
  logic [S_DATA_COUNT-1:0] sel_onehot;
  logic                    hs;
  logic                    rel;
  int                      cand;
  logic [IDX_WIDTH-1:0]    cand_idx;

  // Beat accepted by the slave, and the beat that ends the packet.
  assign hs  = grant_valid_reg & valid_i & ready_i;
  assign rel = hs & last_i;

  // Cyclic search from ptr: scan offsets from highest to lowest so that the
  // smallest offset (highest priority) is the last one to overwrite sel_idx.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = S_DATA_COUNT - 1; k >= 0; k--) begin
      cand = int'(ptr_reg) + k;
      if (cand >= S_DATA_COUNT) begin
        cand = cand - S_DATA_COUNT;
      end
      cand_idx = cand[IDX_WIDTH-1:0];
      if (req_i[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // The winner gets lowest priority next time: pointer moves just past it.
  assign sel_ptr_next = (sel_idx == IDX_WIDTH'(S_DATA_COUNT - 1)) ? '0
                                                                   : sel_idx + IDX_WIDTH'(1);

  // One-hot decode of the selected index.
  for (genvar gi = 0; gi < S_DATA_COUNT; gi++) begin : g_onehot
    assign sel_onehot[gi] = sel_found && (sel_idx == IDX_WIDTH'(gi));
  end

  // Next-state and next-grant logic; a grant only changes from IDLE or on release.
  always_comb begin
    state_next       = state_reg;
    ptr_next         = ptr_reg;
    grant_next       = grant_reg;
    idx_next         = idx_reg;
    grant_valid_next = grant_valid_reg;
    if ((state_reg == IDLE) || rel) begin
      if (sel_found) begin
        state_next       = LOCKED;
        ptr_next         = sel_ptr_next;
        grant_next       = sel_onehot;
        idx_next         = sel_idx;
        grant_valid_next = 1'b1;
      end else begin
        state_next       = IDLE;
        grant_next       = '0;
        idx_next         = '0;
        grant_valid_next = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      grant_reg       <= '0;
      idx_reg         <= '0;
      grant_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      grant_reg       <= grant_next;
      idx_reg         <= idx_next;
      grant_valid_reg <= grant_valid_next;
    end
  end

  assign grant_o       = grant_reg;
  assign grant_idx_o   = idx_reg;
  assign grant_valid_o = grant_valid_reg;

endmodule

// File: tb/tb_xbar_arbiter.sv
// Testbench for xbar_arbiter with three masters: directed scenarios with
// literal expectations, then random traffic, all compared every cycle against
// a packet-level model (current owner + round-robin pointer).
module tb_xbar_arbiter;

  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [S-1:0] req;
  logic         valid;
  logic         ready;
  logic         last;
  logic [S-1:0] grant;
  logic [1:0]   grant_idx;
  logic         grant_valid;

  int checks = 0;
  int passes = 0;
  int cycles = 0;

  // Model: owner = master holding the slave (-1 when nobody), ptr = search start.
  int m_owner = -1;
  int m_ptr   = 0;

  xbar_arbiter #(.S_DATA_COUNT(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .valid_i      (valid),
    .ready_i      (ready),
    .last_i       (last),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .grant_valid_o(grant_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cycles);
  endtask

  // Model update: a packet ends when its last beat is accepted; then (or when
  // idle) the first requester at or after ptr, cyclically, becomes the owner.
  always @(posedge clk) begin
    bit found;
    cycles++;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if ((m_owner < 0) || (valid && ready && last)) begin
      found = 0;
      for (int k = 0; k < S; k++) begin
        int c;
        c = (m_ptr + k) % S;
        if (!found && req[c]) begin
          found   = 1;
          m_owner = c;
          m_ptr   = (c + 1) % S;
        end
      end
      if (!found) m_owner = -1;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (cycles > 0) begin
      chk("model_grant", int'(grant), (m_owner >= 0) ? (1 << m_owner) : 0);
      chk("model_idx", int'(grant_idx), (m_owner >= 0) ? m_owner : 0);
      chk("model_valid", int'(grant_valid), (m_owner >= 0) ? 1 : 0);
    end
  end

  // Apply one cycle of inputs; returns after the edge that consumed them.
  task automatic tick(input logic r, input logic [S-1:0] q, input logic v,
                      input logic rd, input logic l);
    rst   = r;
    req   = q;
    valid = v;
    ready = rd;
    last  = l;
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input int g, input int idx, input int gv);
    chk({name, "_grant"}, int'(grant), g);
    chk({name, "_idx"}, int'(grant_idx), idx);
    chk({name, "_valid"}, int'(grant_valid), gv);
  endtask

  // Directed scenarios followed by random traffic.
  initial begin
    tick(1, 3'b000, 0, 0, 0);
    tick(1, 3'b111, 1, 1, 1);
    expect_out("reset", 0, 0, 0);

    // Single request: master 1 granted one cycle later, pointer moves to 2.
    tick(0, 3'b010, 0, 0, 0);
    expect_out("single", 3'b010, 1, 1);
    chk("single_ptr", m_ptr, 2);

    // Release to idle, then 3'b011 from ptr=2 wraps to master 0.
    tick(0, 3'b000, 1, 1, 1);
    expect_out("rel_idle", 0, 0, 0);
    tick(0, 3'b011, 0, 0, 0);
    expect_out("wrap", 3'b001, 0, 1);

    // Fairness: all request, 1-beat packets, restarted from ptr=0.
    tick(1, 3'b000, 0, 0, 0);
    tick(0, 3'b111, 0, 0, 0);
    chk("fair0_idx", int'(grant_idx), 0);
    tick(0, 3'b111, 1, 1, 1);
    chk("fair1_idx", int'(grant_idx), 1);
    tick(0, 3'b111, 1, 1, 1);
    chk("fair2_idx", int'(grant_idx), 2);
    tick(0, 3'b111, 1, 1, 1);
    chk("fair3_idx", int'(grant_idx), 0);
    tick(0, 3'b111, 1, 1, 1);
    chk("fair4_idx", int'(grant_idx), 1);
    chk("fair4_valid", int'(grant_valid), 1);
    tick(0, 3'b000, 1, 1, 1);
    expect_out("fair_end", 0, 0, 0);

    // Lock: master 0 holds through a 4-beat packet while req moves to master 2.
    tick(0, 3'b001, 0, 0, 0);
    expect_out("lock_start", 3'b001, 0, 1);
    tick(0, 3'b001, 1, 0, 0);
    chk("lock_a", int'(grant_idx), 0);
    tick(0, 3'b001, 1, 1, 0);
    chk("lock_b1", int'(grant_idx), 0);
    tick(0, 3'b100, 1, 0, 0);
    chk("lock_c", int'(grant_idx), 0);
    tick(0, 3'b100, 1, 1, 0);
    chk("lock_b2", int'(grant_idx), 0);
    tick(0, 3'b100, 1, 1, 0);
    chk("lock_b3", int'(grant_idx), 0);
    tick(0, 3'b100, 1, 0, 1);
    chk("lock_nohs_last", int'(grant_idx), 0);
    tick(0, 3'b100, 1, 1, 1);
    expect_out("lock_next", 3'b100, 2, 1);
    tick(0, 3'b000, 1, 1, 1);
    expect_out("lock_idle", 0, 0, 0);

    // Stall: last presented but never accepted for 10 cycles.
    tick(0, 3'b010, 0, 0, 0);
    expect_out("stall_start", 3'b010, 1, 1);
    for (int i = 0; i < 10; i++) begin
      tick(0, 3'($urandom_range(0, 7)), 1, 0, 1);
      chk("stall_idx", int'(grant_idx), 1);
    end

    // Reset mid-packet from master 2, then 3'b110 restarts from ptr=0.
    tick(0, 3'b100, 1, 1, 1);
    expect_out("rst_pkt", 3'b100, 2, 1);
    tick(0, 3'b100, 1, 1, 0);
    chk("rst_beat1", int'(grant_idx), 2);
    tick(1, 3'b100, 1, 1, 0);
    expect_out("rst_mid", 0, 0, 0);
    tick(0, 3'b110, 0, 0, 0);
    expect_out("rst_after", 3'b010, 1, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 60) == 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
